// File: rtl/lc3_pkg.sv
// Shared LC-3 writeback definitions: source encodings, FSM states, CC reset value.
package lc3_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2,
        WB_PC   = 2'd3
    } wb_src_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_WRITE    = 2'd2,
        ST_RETIRE   = 2'd3
    } wb_state_t;

    // {N,Z,P} after reset: Z set
    localparam logic [2:0] CC_RESET = 3'b010;

endpackage

// File: rtl/lc3_cc_logic.sv
// Combinational one-hot NZP decode of a data word; shared with branch logic.
module lc3_cc_logic
    import lc3_pkg::*;
#(
    parameter int DATA_W_P = lc3_pkg::DATA_W
) (
    input  logic [DATA_W_P-1:0] value,
    output logic [2:0]          nzp
);

    // Sign bit wins, then zero, otherwise positive
    always_comb begin
        nzp = 3'b001;
        if (value[DATA_W_P-1])
            nzp = 3'b100;
        else if (value == '0)
            nzp = 3'b010;
    end

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: selects the result source, waits for loads,
// drives the register-file write port and keeps the NZP register.
//
// state       | meaning
// ------------+--------------------------------------------------------
// ST_IDLE     | ready; accept a result from execute
// ST_WAIT_MEM | waiting for load data, timeout counter running
// ST_WRITE    | one-cycle register-file write, optional CC update
// ST_RETIRE   | one-cycle retire without a write (NONE or load timeout)
module lc3_writeback
    import lc3_pkg::*;
#(
    parameter int DATA_W      = lc3_pkg::DATA_W,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              WB_VALID,
    output logic              WB_READY,
    input  logic [1:0]        WB_SRC,
    input  logic [2:0]        WB_DEST,
    input  logic              WB_SET_CC,
    input  logic [DATA_W-1:0] ALU_RESULT,
    input  logic [DATA_W-1:0] PC_PLUS1,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_RVALID,
    output logic              RD_LE,
    output logic [2:0]        RD,
    output logic [DATA_W-1:0] DATA_IN,
    output logic              CC_N,
    output logic              CC_Z,
    output logic              CC_P,
    output logic              WB_DONE,
    output logic              WB_ERR
);

    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    wb_state_t         state, next_state;
    wb_src_t           src;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic [2:0]        cap_dest;
    logic              cap_set_cc;
    logic [2:0]        cc_q;
    logic [2:0]        cc_from_data;

    logic              rd_le_nxt;
    logic [2:0]        rd_nxt;
    logic [DATA_W-1:0] data_in_nxt;
    logic              done_nxt;
    logic              err_set;
    logic              cc_load;
    logic              accept;

    assign src    = wb_src_t'(WB_SRC);
    assign accept = (state == ST_IDLE) && WB_VALID;

    lc3_cc_logic #(.DATA_W_P(DATA_W)) u_cc_logic (
        .value (DATA_IN),
        .nzp   (cc_from_data)
    );

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state decode
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (WB_VALID) begin
                    case (src)
                        WB_ALU, WB_PC: next_state = ST_WRITE;
                        WB_MEM:        next_state = ST_WAIT_MEM;
                        default:       next_state = ST_RETIRE;
                    endcase
                end
            end
            ST_WAIT_MEM: begin
                if (MEM_RVALID)
                    next_state = ST_WRITE;
                else if (to_cnt == TO_MAX)
                    next_state = ST_RETIRE;
            end
            ST_WRITE:  next_state = ST_IDLE;
            ST_RETIRE: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Output decode: next values of the registered outputs
    always_comb begin
        rd_le_nxt   = (next_state == ST_WRITE);
        done_nxt    = (next_state == ST_WRITE) || (next_state == ST_RETIRE);
        rd_nxt      = RD;
        data_in_nxt = DATA_IN;
        if (next_state == ST_WRITE) begin
            if (state == ST_IDLE) begin
                rd_nxt      = WB_DEST;
                data_in_nxt = (src == WB_PC) ? PC_PLUS1 : ALU_RESULT;
            end else begin
                rd_nxt      = cap_dest;
                data_in_nxt = MEM_RDATA;
            end
        end
        err_set = (state == ST_WAIT_MEM) && !MEM_RVALID && (to_cnt == TO_MAX);
        cc_load = (state == ST_WRITE) && cap_set_cc;
        WB_READY = (state == ST_IDLE);
        to_cnt_nxt = to_cnt;
        if (state == ST_IDLE)
            to_cnt_nxt = '0;
        else if ((state == ST_WAIT_MEM) && !MEM_RVALID && (to_cnt != TO_MAX))
            to_cnt_nxt = to_cnt + 1'b1;
    end

    // Registered outputs, captured instruction fields, CC and timeout counter
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RD_LE      <= 1'b0;
            RD         <= '0;
            DATA_IN    <= '0;
            WB_DONE    <= 1'b0;
            WB_ERR     <= 1'b0;
            cc_q       <= CC_RESET;
            to_cnt     <= '0;
            cap_dest   <= '0;
            cap_set_cc <= 1'b0;
        end else begin
            RD_LE   <= rd_le_nxt;
            RD      <= rd_nxt;
            DATA_IN <= data_in_nxt;
            WB_DONE <= done_nxt;
            to_cnt  <= to_cnt_nxt;
            if (err_set)
                WB_ERR <= 1'b1;
            if (cc_load)
                cc_q <= cc_from_data;
            if (accept) begin
                cap_dest   <= WB_DEST;
                // a NONE result never writes, so it never touches CC
                cap_set_cc <= WB_SET_CC && (src != WB_NONE);
            end
        end
    end

    assign CC_N = cc_q[2];
    assign CC_Z = cc_q[1];
    assign CC_P = cc_q[0];

endmodule
